path_buffer: RTL
================

// Module: path_buffer
// PURPOSE
//  Parametrised dual-mode location store for the maze/path datapath.
//  Records locations in LIFO order while searching; backtracking pops the top entry.
//  After a `replay` pulse it streams the recorded path non-destructively, oldest entry first (FIFO order).
//  Adds full/empty/count status, error flags and a registered, valid-qualified output.
// PARAMETERS
//  WIDTH  8    bits per stored location
//  DEPTH  256  number of entries (any value >=2; need not be a power of 2)
//  CW     $clog2(DEPTH+1)  derived count width (localparam, not overridable)
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst        in   1      synchronous reset, active-low (sampled on posedge clk)
//  push       in   1      write data_in (STACK mode only)
//  pop        in   1      read request (destructive in STACK, non-destructive in REPLAY)
//  replay     in   1      one-cycle pulse: enter REPLAY mode, rewind read pointer to oldest entry
//  clear      in   1      one-cycle pulse: discard contents, return to STACK mode
//  data_in    in   WIDTH  location to push
//  data_out   out  WIDTH  popped location, registered
//  out_valid  out  1      data_out is valid this cycle (one-cycle pulse per accepted pop)
//  empty      out  1      STACK: count==0; REPLAY: rd_ptr==count
//  full       out  1      count==DEPTH
//  count      out  CW     number of stored entries
//  mode       out  1      0 = STACK, 1 = REPLAY
//  err        out  1      one-cycle pulse on an illegal request (see below)
// BEHAVIOUR
//  Reset (rst==0): mode=STACK, count=0, rd_ptr=0, data_out=0, out_valid=0, err=0.
//    Reset overrides all other inputs and may be asserted mid-operation.
//    Memory contents need not be cleared; they are unreachable once count=0.
//  Priority: rst > clear > replay > push/pop.
//  STACK mode:
//   - push & !full: mem[count] <= data_in; count +1.
//   - pop & !empty: data_out <= mem[count-1]; count -1; out_valid=1 next cycle (latency 1).
//   - push & pop & !empty: data_out <= old top; the top slot is overwritten with data_in; count unchanged.
//   - push & pop & empty: the pop is an underflow (err=1); the push proceeds; count=1.
//   - push & full (no pop): dropped, err=1. pop & empty: dropped, err=1, out_valid=0.
//  REPLAY mode:
//   - pop & rd_ptr<count: data_out <= mem[rd_ptr]; rd_ptr +1; out_valid=1 next cycle.
//   - pop & rd_ptr==count (exhausted): err=1, out_valid=0. count is never changed.
//   - push: ignored, err=1.
//  replay: mode<=REPLAY, rd_ptr<=0. Legal in either mode; in REPLAY it rewinds. Coincident push/pop are ignored.
//  clear: count<=0, rd_ptr<=0, mode<=STACK. Coincident requests are ignored.
//  Pointer arithmetic is unsigned. Indices never exceed DEPTH-1, because the full/empty guards prevent wrap.
//  Status outputs (empty, full, count, mode) are combinational from registered state.
// STRUCTURE
//  Shared header path_buffer_defs.vh: `define MODE_STACK 1'b0, `define MODE_REPLAY 1'b1.
//  Sub-module path_buffer_mem: DEPTH x WIDTH, 1 write port, 1 synchronous read port.
//    Its read-register output is data_out directly, so the 1-cycle latency comes from the RAM.
//  Top level holds the mode register, count, rd_ptr, request decode and err/out_valid generation.
// TESTING
//  1 Reset: drive rst=0 for 2 cycles with push=1 -> count=0, empty=1, mode=0, out_valid=0, err=0.
//  2 LIFO: push 8'h11, 8'h22, 8'h33; then pop x3
//      -> data_out 33, 22, 11, each with out_valid one cycle after its pop; afterwards empty=1.
//  3 Full/underflow: DEPTH=4, push 5 times -> full=1 after the 4th push; err pulses on the 5th; count=4.
//      Pop x5 -> the 5th pop gives err=1 and out_valid=0.
//  4 Replay: push 11, 22, 33; pulse replay; pop x4 -> data_out 11, 22, 33 and then err on the 4th pop; count stays 3.
//      Pulse replay again and pop -> data_out 11.
//  5 Simultaneous ops: contents 11, 22; push 44 with pop in the same cycle -> data_out=22, count=2.
//      Pop -> 44. A push in REPLAY mode -> err=1 and count unchanged.
//  6 Mid-op reset/clear: in REPLAY with rd_ptr=2, pulse clear -> mode=0, count=0.
//      Repeat with rst=0 instead -> same result, and data_out=0.

Source files
------------

// File: rtl/path_buffer_pkg.sv
// path_buffer_pkg
//   Shared types for the path buffer: the operating-mode encoding used by the
//   top level and exported on its `mode` status output.
package path_buffer_pkg;

    // STACK records and backtracks (LIFO). REPLAY streams the recorded path
    // oldest-first without consuming it.
    typedef enum logic {
        MODE_STACK  = 1'b0,
        MODE_REPLAY = 1'b1
    } mode_e;

endpackage : path_buffer_pkg

// File: rtl/path_buffer_mem.sv
// path_buffer_mem
//   DEPTH x WIDTH storage with one write port and one synchronous read port.
//   The read register is the module output, so a read issued in cycle N is
//   visible in cycle N+1. A read and a write to the same address in one cycle
//   return the old contents.
// Ports
//   clk    clock
//   rst    synchronous active-low reset (clears only the read register)
//   we_i   write enable, waddr_i / wdata_i  write address and data
//   re_i   read enable,  raddr_i            read address
//   rdata_o registered read data
module path_buffer_mem #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage has no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : path_buffer_mem

// File: rtl/path_buffer.sv
// path_buffer
//   Dual-mode location store. In STACK mode locations are pushed and popped
//   LIFO; a `replay` pulse switches to REPLAY mode, where pops stream the
//   recorded entries oldest-first without removing them. `clear` empties the
//   store and returns to STACK mode.
// Ports
//   clk, rst              clock, synchronous active-low reset
//   push, pop             write / read requests
//   replay, clear         mode-control pulses (priority rst > clear > replay > push/pop)
//   data_in               location to push
//   data_out, out_valid   registered read data and its one-cycle valid pulse
//   empty, full, count    occupancy status (combinational from registered state)
//   mode                  0 = STACK, 1 = REPLAY
//   err                   one-cycle pulse on an illegal request
module path_buffer
    import path_buffer_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             replay,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             mode,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);

    mode_e         mode_q, mode_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] top_addr;
    logic          empty_s;
    logic          full_s;

    // In REPLAY the store is "empty" once the read pointer has walked past
    // the newest entry, even though count is unchanged.
    assign empty_s  = (mode_q == MODE_STACK) ? (count_q == '0) : (rd_ptr_q == count_q);
    assign full_s   = (count_q == CW'(DEPTH));
    assign top_addr = AW'(count_q - CW'(1));

    always_comb begin
        mode_d      = mode_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = AW'(count_q);
        mem_re      = 1'b0;
        mem_raddr   = AW'(rd_ptr_q);

        if (clear) begin
            count_d  = '0;
            rd_ptr_d = '0;
            mode_d   = MODE_STACK;
        end else if (replay) begin
            mode_d   = MODE_REPLAY;
            rd_ptr_d = '0;
        end else if (mode_q == MODE_STACK) begin
            if (push && pop) begin
                if (!empty_s) begin
                    // Swap the top: the RAM returns the old top while the
                    // same slot takes the new location.
                    mem_re      = 1'b1;
                    mem_raddr   = top_addr;
                    mem_we      = 1'b1;
                    mem_waddr   = top_addr;
                    out_valid_d = 1'b1;
                end else begin
                    // Underflowing pop is flagged; the push still lands.
                    // DEPTH >= 2 guarantees an empty store is never full.
                    err_d   = 1'b1;
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end else if (push) begin
                if (!full_s) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (pop) begin
                if (!empty_s) begin
                    mem_re      = 1'b1;
                    mem_raddr   = top_addr;
                    count_d     = count_q - CW'(1);
                    out_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            if (push) begin
                err_d = 1'b1;
            end
            if (pop) begin
                if (rd_ptr_q < count_q) begin
                    mem_re      = 1'b1;
                    rd_ptr_d    = rd_ptr_q + CW'(1);
                    out_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= MODE_STACK;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    path_buffer_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we_i   (mem_we & rst),
        .waddr_i(mem_waddr),
        .wdata_i(data_in),
        .re_i   (mem_re),
        .raddr_i(mem_raddr),
        .rdata_o(data_out)
    );

    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign count     = count_q;
    assign mode      = mode_q;

endmodule : path_buffer
